hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/pipeline_pkg.sv | 25 ++
 rtl/hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: hazard FSM states and ALU operand-forwarding selects.
package pipeline_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MEM_WAIT = 2'b01,
      ST_FLUSH    = 2'b10
   } hz_state_e;

   typedef enum logic [1:0] {
      FWD_RF     = 2'b00,
      FWD_MEM_WB = 2'b01,
      FWD_EX_MEM = 2'b10
   } fwd_sel_e;

   localparam int unsigned STALL_W = 16;

   // The newer producer (EX_MEM) wins over the older one (MEM_WB).
   function automatic fwd_sel_e fwd_select(input logic ex_hit, input logic wb_hit);
      if (ex_hit) return FWD_EX_MEM;
      if (wb_hit) return FWD_MEM_WB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory waits
// with timeout, and EX-stage operand forwarding selects.
module hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned FLUSH_EXTRA = 1,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] IF_ID_Rs,
   input  logic [REG_AW-1:0] IF_ID_Rt,
   input  logic [REG_AW-1:0] ID_EX_Rs,
   input  logic [REG_AW-1:0] ID_EX_Rt,
   input  logic [REG_AW-1:0] ID_EX_Rd,
   input  logic              ID_EX_MemRead,
   input  logic [REG_AW-1:0] EX_MEM_WriteReg,
   input  logic              EX_MEM_RegWrite,
   input  logic [REG_AW-1:0] MEM_WB_WriteReg,
   input  logic              MEM_WB_RegWrite,
   input  logic              EX_MEM_Branch,
   input  logic              EX_MEM_MemRead,
   input  logic              EX_MEM_MemWrite,
   input  logic              mem_ready,
   output logic              pc_en,
   output logic              if_id_en,
   output logic              id_ex_en,
   output logic              ex_mem_en,
   output logic              mem_wb_en,
   output logic              if_id_flush,
   output logic              id_ex_bubble,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [1:0]        state,
   output logic [15:0]       stall_cnt,
   output logic              mem_timeout
);

   localparam int unsigned        WAIT_W     = $clog2(MEM_TIMEOUT + 1);
   localparam int unsigned        FLUSH_W    = 2;
   localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
   localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(FLUSH_EXTRA);

   hz_state_e            state_q, state_d;
   logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic                 branch_pend_q, branch_pend_d;
   logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic                 mem_timeout_q, mem_timeout_d;

   logic mem_stall_c, load_use_c;
   logic ex_hit_a_c, wb_hit_a_c, ex_hit_b_c, wb_hit_b_c;

   assign mem_stall_c = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~mem_ready;
   assign load_use_c  = ID_EX_MemRead & (ID_EX_Rd != '0) &
                        ((ID_EX_Rd == IF_ID_Rs) | (ID_EX_Rd == IF_ID_Rt));

   assign ex_hit_a_c = EX_MEM_RegWrite & (EX_MEM_WriteReg != '0) & (EX_MEM_WriteReg == ID_EX_Rs);
   assign wb_hit_a_c = MEM_WB_RegWrite & (MEM_WB_WriteReg != '0) & (MEM_WB_WriteReg == ID_EX_Rs);
   assign ex_hit_b_c = EX_MEM_RegWrite & (EX_MEM_WriteReg != '0) & (EX_MEM_WriteReg == ID_EX_Rt);
   assign wb_hit_b_c = MEM_WB_RegWrite & (MEM_WB_WriteReg != '0) & (MEM_WB_WriteReg == ID_EX_Rt);

   assign fwd_a       = rst ? fwd_select(ex_hit_a_c, wb_hit_a_c) : FWD_RF;
   assign fwd_b       = rst ? fwd_select(ex_hit_b_c, wb_hit_b_c) : FWD_RF;
   assign state       = 2'(state_q);
   assign stall_cnt   = stall_cnt_q;
   assign mem_timeout = mem_timeout_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_RUN;
         wait_cnt_q    <= '0;
         flush_cnt_q   <= '0;
         branch_pend_q <= 1'b0;
         stall_cnt_q   <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
         branch_pend_q <= branch_pend_d;
         stall_cnt_q   <= stall_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      flush_cnt_d   = flush_cnt_q;
      branch_pend_d = branch_pend_q;
      mem_timeout_d = mem_timeout_q;
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      id_ex_en      = 1'b1;
      ex_mem_en     = 1'b1;
      mem_wb_en     = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;

      unique case (state_q)
         ST_RUN, ST_FLUSH: begin
            if (mem_stall_c) begin
               {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
               // A branch frozen behind the wait is replayed when memory releases.
               branch_pend_d = (state_q == ST_RUN) & EX_MEM_Branch;
               flush_cnt_d   = '0;
            end else if (state_q == ST_FLUSH) begin
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               if (flush_cnt_q <= FLUSH_W'(1)) begin
                  flush_cnt_d = '0;
                  state_d     = ST_RUN;
               end else begin
                  flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
               end
            end else if (EX_MEM_Branch) begin
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               if (FLUSH_EXTRA != 0) begin
                  state_d     = ST_FLUSH;
                  flush_cnt_d = FLUSH_INIT;
               end
            end else if (load_use_c) begin
               pc_en        = 1'b0;
               if_id_en     = 1'b0;
               id_ex_bubble = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ready || (wait_cnt_q >= WAIT_MAX)) begin
               if (!mem_ready) mem_timeout_d = 1'b1;
               wait_cnt_d    = '0;
               state_d       = ST_RUN;
               branch_pend_d = 1'b0;
               if (branch_pend_q) begin
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
                  if (FLUSH_EXTRA != 0) begin
                     state_d     = ST_FLUSH;
                     flush_cnt_d = FLUSH_INIT;
                  end
               end
            end else begin
               {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         default: state_d = ST_RUN;
      endcase

      stall_cnt_d = (!pc_en && (stall_cnt_q != '1)) ? stall_cnt_q + STALL_W'(1) : stall_cnt_q;

      // Reset presents a free-running, non-flushing pipeline.
      if (!rst) begin
         {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
         if_id_flush  = 1'b0;
         id_ex_bubble = 1'b0;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver pushes model expectations, monitor pops and compares.
module tb_hazard_ctrl;

   localparam int unsigned AW  = 5;
   localparam int unsigned FX  = 1;
   localparam int unsigned MTO = 16;

   typedef struct packed {
      logic [AW-1:0] if_rs, if_rt, ex_rs, ex_rt, ex_rd;
      logic          ex_mr;
      logic [AW-1:0] mem_wr;
      logic          mem_rw;
      logic [AW-1:0] wb_wr;
      logic          wb_rw;
      logic          br, mrd, mwr, rdy;
   } in_t;

   typedef struct packed {
      logic [4:0]  en;
      logic        fl, bu;
      logic [1:0]  fa, fb, st;
      logic [15:0] sc;
      logic        to;
   } exp_t;

   logic clk, rst;
   in_t  cur;
   logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble, mem_timeout;
   logic [1:0]  fwd_a, fwd_b, state;
   logic [15:0] stall_cnt;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model: booleans and integer counts of elapsed events.
   bit m_waiting;
   int m_waited, m_flush_left, m_stalls;
   bit m_defer, m_to;

   hazard_ctrl #(.REG_AW(AW), .FLUSH_EXTRA(FX), .MEM_TIMEOUT(MTO)) dut (
      .clk(clk), .rst(rst),
      .IF_ID_Rs(cur.if_rs), .IF_ID_Rt(cur.if_rt),
      .ID_EX_Rs(cur.ex_rs), .ID_EX_Rt(cur.ex_rt), .ID_EX_Rd(cur.ex_rd),
      .ID_EX_MemRead(cur.ex_mr),
      .EX_MEM_WriteReg(cur.mem_wr), .EX_MEM_RegWrite(cur.mem_rw),
      .MEM_WB_WriteReg(cur.wb_wr), .MEM_WB_RegWrite(cur.wb_rw),
      .EX_MEM_Branch(cur.br), .EX_MEM_MemRead(cur.mrd), .EX_MEM_MemWrite(cur.mwr),
      .mem_ready(cur.rdy),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state), .stall_cnt(stall_cnt),
      .mem_timeout(mem_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [1:0] fwd_model(input logic [AW-1:0] src, input in_t t);
      if (t.mem_rw && t.mem_wr != 0 && t.mem_wr == src) return 2'b10;
      if (t.wb_rw && t.wb_wr != 0 && t.wb_wr == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic in_t rnd();
      in_t t;
      t.if_rs  = AW'($urandom_range(0, 3));
      t.if_rt  = AW'($urandom_range(0, 3));
      t.ex_rs  = AW'($urandom_range(0, 3));
      t.ex_rt  = AW'($urandom_range(0, 3));
      t.ex_rd  = AW'($urandom_range(0, 3));
      t.ex_mr  = ($urandom_range(0, 9) < 4);
      t.mem_wr = AW'($urandom_range(0, 3));
      t.mem_rw = ($urandom_range(0, 9) < 6);
      t.wb_wr  = AW'($urandom_range(0, 3));
      t.wb_rw  = ($urandom_range(0, 9) < 6);
      t.br     = ($urandom_range(0, 9) < 1);
      t.mrd    = ($urandom_range(0, 9) < 2);
      t.mwr    = ($urandom_range(0, 9) < 1);
      t.rdy    = ($urandom_range(0, 9) < 6);
      return t;
   endfunction

   task automatic model_reset();
      m_waiting = 0; m_waited = 0; m_flush_left = 0; m_stalls = 0; m_defer = 0; m_to = 0;
   endtask

   task automatic model_step(input in_t t);
      exp_t e;
      bit   blocked, lu;
      e.st = m_waiting ? 2'b01 : (m_flush_left > 0 ? 2'b10 : 2'b00);
      e.sc = 16'(m_stalls);
      e.to = m_to;
      e.en = 5'b11111; e.fl = 1'b0; e.bu = 1'b0;
      e.fa = fwd_model(t.ex_rs, t);
      e.fb = fwd_model(t.ex_rt, t);
      blocked = (t.mrd || t.mwr) && !t.rdy;
      lu = t.ex_mr && t.ex_rd != 0 && (t.ex_rd == t.if_rs || t.ex_rd == t.if_rt);
      if (m_waiting) begin
         if (t.rdy || m_waited >= int'(MTO)) begin
            if (!t.rdy) m_to = 1;
            m_waiting = 0;
            if (m_defer) begin
               e.fl = 1'b1; e.bu = 1'b1; m_flush_left = int'(FX);
            end
            m_defer = 0;
         end else begin
            e.en = 5'b00000; m_waited++;
         end
      end else if (blocked) begin
         e.en = 5'b00000;
         m_defer = (m_flush_left == 0) && t.br;
         m_waiting = 1; m_waited = 1; m_flush_left = 0;
      end else if (m_flush_left > 0) begin
         e.fl = 1'b1; e.bu = 1'b1; m_flush_left--;
      end else if (t.br) begin
         e.fl = 1'b1; e.bu = 1'b1; m_flush_left = int'(FX);
      end else if (lu) begin
         e.en = 5'b00111; e.bu = 1'b1;
      end
      if (!e.en[4] && m_stalls < 65535) m_stalls++;
      q.push_back(e);
   endtask

   // Apply one cycle of stimulus (r=0 holds reset) and queue its expectation.
   task automatic drive(input in_t t, input logic r);
      exp_t e;
      cur = t;
      rst = r;
      if (!r) begin
         model_reset();
         e = '0;
         e.en = 5'b11111;
         q.push_back(e);
      end else begin
         model_step(t);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s @%0t: got %h required %h", name, $time, act, req);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("enables", 16'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 16'(e.en));
            chk("if_id_flush", 16'(if_id_flush), 16'(e.fl));
            chk("id_ex_bubble", 16'(id_ex_bubble), 16'(e.bu));
            chk("fwd_a", 16'(fwd_a), 16'(e.fa));
            chk("fwd_b", 16'(fwd_b), 16'(e.fb));
            chk("state", 16'(state), 16'(e.st));
            chk("stall_cnt", stall_cnt, e.sc);
            chk("mem_timeout", 16'(mem_timeout), 16'(e.to));
         end
      end
   end

   initial begin : stimulus
      in_t t;
      rst = 1'b0;
      cur = '0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) drive(rnd(), 1'b0);
      drive('0, 1'b1);

      t = '0; t.ex_mr = 1; t.ex_rd = 5; t.if_rs = 5;
      drive(t, 1'b1);
      drive('0, 1'b1);

      t = '0; t.mem_wr = 3; t.wb_wr = 3; t.ex_rs = 3; t.ex_rt = 3; t.mem_rw = 1; t.wb_rw = 1;
      drive(t, 1'b1);
      t.mem_rw = 0;
      drive(t, 1'b1);
      t.mem_wr = 0; t.wb_wr = 0; t.ex_rs = 0; t.ex_rt = 0; t.mem_rw = 1;
      drive(t, 1'b1);

      t = '0; t.br = 1;
      drive(t, 1'b1);
      for (int i = 0; i < 3; i++) drive('0, 1'b1);

      t = '0; t.mrd = 1;
      for (int i = 0; i < 3; i++) drive(t, 1'b1);
      t.rdy = 1;
      drive(t, 1'b1);
      drive('0, 1'b1);

      t = '0; t.mrd = 1; t.br = 1;
      for (int i = 0; i < 2; i++) drive(t, 1'b1);
      t.rdy = 1;
      drive(t, 1'b1);
      for (int i = 0; i < 3; i++) drive('0, 1'b1);

      t = '0; t.mwr = 1;
      for (int i = 0; i < 20; i++) drive(t, 1'b1);
      for (int i = 0; i < 2; i++) drive('0, 1'b1);

      for (int i = 0; i < 2000; i++) drive(rnd(), 1'b1);

      t = '0; t.mrd = 1;
      for (int i = 0; i < 3; i++) drive(t, 1'b1);
      for (int i = 0; i < 2; i++) drive(t, 1'b0);
      drive('0, 1'b1);
      t = '0; t.br = 1;
      drive(t, 1'b1);
      drive('0, 1'b0);
      for (int i = 0; i < 2; i++) drive('0, 1'b1);

      for (int i = 0; i < 500; i++) drive(rnd(), 1'b1);

      @(negedge clk);
      #1;
      n_cmp++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
